// File: rtl/game_pkg.sv
// Shared definitions for the game control path: state encoding and position packing.
package game_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_PLAY    = 3'd1;
  localparam logic [2:0] ST_PAUSE   = 3'd2;
  localparam logic [2:0] ST_RESPAWN = 3'd3;
  localparam logic [2:0] ST_OVER    = 3'd4;

  localparam int unsigned POS_W   = 20;
  localparam int unsigned COORD_W = 10;
  localparam int unsigned Y_LSB   = 10;
  localparam int unsigned X_LSB   = 0;

  // Packs a coordinate pair into the {y, x} position word.
  function automatic logic [POS_W-1:0] pack_pos(input logic [COORD_W-1:0] y,
                                                input logic [COORD_W-1:0] x);
    pack_pos = '0;
    pack_pos[Y_LSB +: COORD_W] = y;
    pack_pos[X_LSB +: COORD_W] = x;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Registered rising-edge detector: one-cycle pulse on a 0->1 transition of a level input.
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic i_level,
  output logic o_pulse_c
);

  logic r_level_q;

  always_ff @(posedge clk) begin
    if (reset) r_level_q <= 1'b0;
    else       r_level_q <= i_level;
  end

  assign o_pulse_c = i_level & ~r_level_q;

endmodule

// File: rtl/game_sequencer.sv
// Game state controller: owns the square position and runs the
// start/pause/respawn/game-over flow with lives and score tracking.
module game_sequencer
  import game_pkg::*;
#(
  parameter int unsigned X_INIT         = 300,
  parameter int unsigned Y_INIT         = 220,
  parameter int unsigned LIVES_INIT     = 3,
  parameter int unsigned RESPAWN_FRAMES = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btnC,
  input  logic        refresh_tick,
  input  logic [19:0] position_next,
  input  logic        hit,
  input  logic        goal,
  output logic [19:0] position,
  output logic        status,
  output logic [2:0]  state,
  output logic [1:0]  lives,
  output logic [7:0]  score,
  output logic        game_over
);

  localparam int unsigned CNT_W = 8;
  localparam logic [POS_W-1:0] SPAWN     = pack_pos(COORD_W'(Y_INIT), COORD_W'(X_INIT));
  localparam logic [1:0]       LIVES_RST = 2'(LIVES_INIT);
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(RESPAWN_FRAMES);

  logic              w_start;
  logic [2:0]        r_state,    w_state_next;
  logic [POS_W-1:0]  r_position, w_position_next;
  logic [1:0]        r_lives,    w_lives_next;
  logic [7:0]        r_score,    w_score_next;
  logic [CNT_W-1:0]  r_resp_cnt, w_resp_cnt_next;
  logic              r_status;
  logic              r_game_over;
  logic              w_hit_fired;

  edge_detect u_start_edge (
    .clk       (clk),
    .reset     (reset),
    .i_level   (btnC),
    .o_pulse_c (w_start)
  );

  // Next-state and datapath update rules.
  always_comb begin
    w_state_next    = r_state;
    w_position_next = r_position;
    w_lives_next    = r_lives;
    w_score_next    = r_score;
    w_resp_cnt_next = r_resp_cnt;
    w_hit_fired     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_position_next = SPAWN;
        w_lives_next    = LIVES_RST;
        w_score_next    = '0;
        if (w_start) w_state_next = ST_PLAY;
      end
      ST_PLAY: begin
        if (refresh_tick) begin
          if (hit) begin
            w_hit_fired = 1'b1;
            if (r_lives == 2'd1) begin
              w_lives_next = 2'd0;
              w_state_next = ST_OVER;
            end else begin
              w_lives_next    = r_lives - 2'd1;
              w_position_next = SPAWN;
              w_resp_cnt_next = CNT_LOAD;
              w_state_next    = ST_RESPAWN;
            end
          end else if (goal) begin
            w_score_next    = (r_score == 8'hFF) ? r_score : r_score + 8'd1;
            w_position_next = SPAWN;
          end else begin
            w_position_next = position_next;
          end
        end
        // A hit in the same frame takes precedence over a pause request.
        if (w_start && !w_hit_fired) w_state_next = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (w_start) w_state_next = ST_PLAY;
      end
      ST_RESPAWN: begin
        if (refresh_tick) begin
          if (r_resp_cnt != '0) w_resp_cnt_next = r_resp_cnt - CNT_W'(1);
          if (r_resp_cnt <= CNT_W'(1)) w_state_next = ST_PLAY;
        end
      end
      ST_OVER: begin
        if (w_start) begin
          w_state_next    = ST_IDLE;
          w_position_next = SPAWN;
          w_lives_next    = LIVES_RST;
          w_score_next    = '0;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State and datapath registers; status flags decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_position  <= SPAWN;
      r_lives     <= LIVES_RST;
      r_score     <= '0;
      r_resp_cnt  <= '0;
      r_status    <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_position  <= w_position_next;
      r_lives     <= w_lives_next;
      r_score     <= w_score_next;
      r_resp_cnt  <= w_resp_cnt_next;
      r_status    <= (w_state_next == ST_PLAY);
      r_game_over <= (w_state_next == ST_OVER);
    end
  end

  assign position  = r_position;
  assign status    = r_status;
  assign state     = r_state;
  assign lives     = r_lives;
  assign score     = r_score;
  assign game_over = r_game_over;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed vector table, score saturation run,
// and randomized traffic against a behavioural game model.
module tb_game_sequencer;

  localparam int RF = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        btnC = 1'b0;
  logic        refresh_tick = 1'b0;
  logic [19:0] position_next = '0;
  logic        hit = 1'b0;
  logic        goal = 1'b0;
  logic [19:0] position;
  logic        status;
  logic [2:0]  state;
  logic [1:0]  lives;
  logic [7:0]  score;
  logic        game_over;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  game_sequencer #(
    .X_INIT(300), .Y_INIT(220), .LIVES_INIT(3), .RESPAWN_FRAMES(RF)
  ) dut (
    .clk(clk), .reset(reset), .btnC(btnC), .refresh_tick(refresh_tick),
    .position_next(position_next), .hit(hit), .goal(goal),
    .position(position), .status(status), .state(state), .lives(lives),
    .score(score), .game_over(game_over)
  );

  typedef struct {
    logic        rst, btn, tick, hit, goal;
    logic [19:0] pn;
    logic [2:0]  st;
    logic [19:0] pos;
    logic [1:0]  lv;
    logic [7:0]  sc;
    logic        status, go;
  } vec_t;

  function automatic logic [19:0] p(input int y, input int x);
    return {10'(y), 10'(x)};
  endfunction

  function automatic vec_t mk(input int rst, input int btn, input int tick, input int h,
                              input int g, input logic [19:0] pn, input int st,
                              input logic [19:0] pos, input int lv, input int sc);
    vec_t v;
    v.rst = 1'(rst); v.btn = 1'(btn); v.tick = 1'(tick); v.hit = 1'(h); v.goal = 1'(g);
    v.pn = pn; v.st = 3'(st); v.pos = pos; v.lv = 2'(lv); v.sc = 8'(sc);
    v.status = (st == 1); v.go = (st == 4);
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input int st, input logic [19:0] pos,
                         input int lv, input int sc);
    chk({tag, " state"}, int'(state), st);
    chk({tag, " position"}, int'(position), int'(pos));
    chk({tag, " lives"}, int'(lives), lv);
    chk({tag, " score"}, int'(score), sc);
    chk({tag, " status"}, int'(status), int'(st == 1));
    chk({tag, " game_over"}, int'(game_over), int'(st == 4));
  endtask

  task automatic drive(input logic r, input logic b, input logic t, input logic h,
                       input logic g, input logic [19:0] pn);
    reset = r; btnC = b; refresh_tick = t; hit = h; goal = g; position_next = pn;
    @(posedge clk);
    #1;
  endtask

  // Behavioural model of the game rules.
  int          m_state, m_lives, m_score, m_cnt;
  logic [19:0] m_pos;
  logic        m_btn_prev;

  task automatic model_step(input logic r, input logic b, input logic t, input logic h,
                            input logic g, input logic [19:0] pn);
    bit press, hit_taken;
    if (r) begin
      m_state = 0; m_pos = p(220, 300); m_lives = 3; m_score = 0; m_cnt = 0;
      m_btn_prev = 1'b0;
      return;
    end
    press = b && !m_btn_prev;
    m_btn_prev = b;
    hit_taken = 0;
    if (m_state == 0) begin
      m_pos = p(220, 300); m_lives = 3; m_score = 0;
      if (press) m_state = 1;
    end else if (m_state == 1) begin
      if (t && h) begin
        hit_taken = 1;
        m_lives = m_lives - 1;
        if (m_lives == 0) m_state = 4;
        else begin
          m_pos = p(220, 300); m_cnt = RF; m_state = 3;
        end
      end else if (t && g) begin
        if (m_score < 255) m_score = m_score + 1;
        m_pos = p(220, 300);
      end else if (t) begin
        m_pos = pn;
      end
      if (press && !hit_taken) m_state = 2;
    end else if (m_state == 2) begin
      if (press) m_state = 1;
    end else if (m_state == 3) begin
      if (t) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) m_state = 1;
      end
    end else begin
      if (press) begin
        m_state = 0; m_pos = p(220, 300); m_lives = 3; m_score = 0;
      end
    end
  endtask

  vec_t vecs[36];
  logic [19:0] sp;

  initial begin
    sp = p(220, 300);
    for (int i = 0; i < 5; i++) vecs[i] = mk(1, 0, 0, 0, 0, 0, 0, sp, 3, 0);
    vecs[5]  = mk(0, 1, 0, 0, 0, 0,          1, sp,         3, 0);
    vecs[6]  = mk(0, 1, 0, 0, 0, 0,          1, sp,         3, 0);
    vecs[7]  = mk(0, 1, 0, 0, 0, 0,          1, sp,         3, 0);
    vecs[8]  = mk(0, 0, 1, 0, 0, p(219,300), 1, p(219,300), 3, 0);
    vecs[9]  = mk(0, 1, 0, 0, 0, 0,          2, p(219,300), 3, 0);
    vecs[10] = mk(0, 0, 1, 0, 0, p(100,100), 2, p(219,300), 3, 0);
    vecs[11] = mk(0, 1, 0, 0, 0, 0,          1, p(219,300), 3, 0);
    vecs[12] = mk(0, 0, 1, 0, 1, p(1,1),     1, sp,         3, 1);
    vecs[13] = mk(0, 0, 1, 0, 0, p(50,60),   1, p(50,60),   3, 1);
    vecs[14] = mk(0, 0, 1, 1, 0, p(9,9),     3, sp,         2, 1);
    vecs[15] = mk(0, 0, 1, 1, 1, p(1,1),     3, sp,         2, 1);
    vecs[16] = mk(0, 1, 0, 0, 0, 0,          3, sp,         2, 1);
    vecs[17] = mk(0, 0, 1, 0, 0, p(2,2),     1, sp,         2, 1);
    vecs[18] = mk(0, 0, 1, 1, 0, 0,          3, sp,         1, 1);
    vecs[19] = mk(0, 0, 1, 0, 0, 0,          3, sp,         1, 1);
    vecs[20] = mk(0, 0, 1, 0, 0, 0,          1, sp,         1, 1);
    vecs[21] = mk(0, 0, 1, 0, 0, p(5,6),     1, p(5,6),     1, 1);
    vecs[22] = mk(0, 0, 1, 1, 0, p(7,7),     4, p(5,6),     0, 1);
    vecs[23] = mk(0, 0, 1, 1, 0, p(7,7),     4, p(5,6),     0, 1);
    vecs[24] = mk(0, 1, 0, 0, 0, 0,          0, sp,         3, 0);
    vecs[25] = mk(0, 0, 0, 0, 0, 0,          0, sp,         3, 0);
    vecs[26] = mk(0, 1, 0, 0, 0, 0,          1, sp,         3, 0);
    vecs[27] = mk(0, 0, 1, 0, 0, p(7,8),     1, p(7,8),     3, 0);
    vecs[28] = mk(0, 1, 1, 1, 0, p(3,3),     3, sp,         2, 0);
    vecs[29] = mk(0, 0, 1, 0, 0, 0,          3, sp,         2, 0);
    vecs[30] = mk(0, 0, 1, 0, 0, 0,          1, sp,         2, 0);
    vecs[31] = mk(0, 1, 1, 0, 1, p(4,4),     2, sp,         2, 1);
    vecs[32] = mk(0, 0, 0, 0, 0, 0,          2, sp,         2, 1);
    vecs[33] = mk(0, 1, 0, 0, 0, 0,          1, sp,         2, 1);
    vecs[34] = mk(0, 0, 1, 1, 0, 0,          3, sp,         1, 1);
    vecs[35] = mk(1, 0, 1, 1, 1, p(8,8),     0, sp,         3, 0);

    for (int i = 0; i < 36; i++) begin
      drive(vecs[i].rst, vecs[i].btn, vecs[i].tick, vecs[i].hit, vecs[i].goal, vecs[i].pn);
      chk_all($sformatf("vec%0d", i), int'(vecs[i].st), vecs[i].pos,
              int'(vecs[i].lv), int'(vecs[i].sc));
    end

    // Score saturation: 256 consecutive goals from a fresh game.
    drive(0, 1, 0, 0, 0, 0);
    chk_all("sat start", 1, sp, 3, 0);
    for (int i = 1; i <= 256; i++) begin
      drive(0, 0, 1, 0, 1, p(i % 1000, 5));
      if (i >= 254) chk_all($sformatf("sat goal%0d", i), 1, sp, 3, (i > 255) ? 255 : i);
    end

    // Randomized traffic against the model.
    model_step(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    chk_all("rand reset", m_state, m_pos, m_lives, m_score);
    for (int c = 0; c < 3000; c++) begin
      logic r, b, t, h, g;
      logic [19:0] pn;
      r  = ($urandom_range(0, 299) == 0);
      b  = ($urandom_range(0, 5) == 0);
      t  = ($urandom_range(0, 3) == 0);
      h  = ($urandom_range(0, 9) == 0);
      g  = ($urandom_range(0, 5) == 0);
      pn = 20'($urandom);
      model_step(r, b, t, h, g, pn);
      drive(r, b, t, h, g, pn);
      chk_all($sformatf("rand%0d", c), m_state, m_pos, m_lives, m_score);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
